// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    STUCK     = 2'd2
  } state_t;

  localparam int         CNT_W_DEF   = 16;
  localparam int         TIMEOUT_DEF = 1024;
  localparam logic [7:0] DUTY_SAT    = 8'd255;

  // Saturate a high-time count into the 8-bit duty field.
  function automatic logic [7:0] duty_sat(input logic [31:0] ht);
    if (ht > 32'd255) begin
      return DUTY_SAT;
    end else begin
      return ht[7:0];
    end
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Input conditioning for pwm_capture: 2-flop synchronizer, optional glitch
// filter (compiled in with PWM_CAPTURE_GLITCH_FILTER_EN) and registered
// edge detection. level, rise and fall are aligned to the same cycle.
module pwm_edge_sync #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  localparam int FILT_DEPTH = FILT_EN ? FILT_LEN : 0;

  logic sync1_r;
  logic sync2_r;
  logic src_s;
  logic prev_r;
  logic rise_r;
  logic fall_r;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pwm_in;
      sync2_r <= sync1_r;
    end
  end

  generate
    if (FILT_DEPTH > 0) begin : g_filter
      localparam int RUN_W = (FILT_DEPTH > 1) ? $clog2(FILT_DEPTH) : 1;
      logic [RUN_W-1:0] run_r;
      logic             filt_r;

      // Accept a new level only after FILT_DEPTH consecutive differing samples.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          run_r  <= '0;
          filt_r <= 1'b0;
        end else if (sync2_r == filt_r) begin
          run_r  <= '0;
        end else if (run_r == RUN_W'(FILT_DEPTH - 1)) begin
          run_r  <= '0;
          filt_r <= sync2_r;
        end else begin
          run_r  <= run_r + RUN_W'(1);
        end
      end

      assign src_s = filt_r;
    end else begin : g_bypass
      assign src_s = sync2_r;
    end
  endgenerate

  // Registered edge detection against the one-cycle delayed copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      prev_r <= src_s;
      rise_r <= src_s & ~prev_r;
      fall_r <= ~src_s & prev_r;
    end
  end

  assign level = prev_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period between qualified rising
// edges and reports stuck-low / stuck-high after TIMEOUT idle cycles.
// Optional glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic [7:0]       duty_cycle,
  output logic             meas_valid,
  output logic             stuck_low,
  output logic             stuck_high
);

  localparam int               IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(TIMEOUT - 1);

  state_t            state_r;
  state_t            state_s;
  logic              level_s;
  logic              rise_s;
  logic              fall_s;
  logic              timeout_s;
  logic [IDLE_W-1:0] idle_r;
  logic [CNT_W-1:0]  per_cnt_r;
  logic [CNT_W-1:0]  high_cnt_r;
  logic [CNT_W-1:0]  high_time_r;
  logic [CNT_W-1:0]  period_r;
  logic [7:0]        duty_r;
  logic              meas_valid_r;
  logic              stuck_low_r;
  logic              stuck_high_r;

  pwm_edge_sync #(.FILT_LEN(FILT_LEN)) u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .level  (level_s),
    .rise   (rise_s),
    .fall   (fall_s)
  );

  // Any edge takes priority over an idle timeout in the same cycle.
  assign timeout_s = (idle_r == IDLE_END) && !rise_s && !fall_s;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= WAIT_EDGE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      WAIT_EDGE, MEASURE: begin
        if (rise_s) begin
          state_s = MEASURE;
        end else if (timeout_s) begin
          state_s = STUCK;
        end else begin
          state_s = state_r;
        end
      end
      STUCK: begin
        if (rise_s) begin
          state_s = MEASURE;
        end else if (fall_s) begin
          state_s = WAIT_EDGE;
        end else begin
          state_s = STUCK;
        end
      end
      default: state_s = WAIT_EDGE;
    endcase
  end

  // Idle counter: cycles since the last edge of either polarity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_r <= '0;
    end else if (rise_s || fall_s || state_r == STUCK) begin
      idle_r <= '0;
    end else if (idle_r != IDLE_END) begin
      idle_r <= idle_r + IDLE_W'(1);
    end else begin
      idle_r <= idle_r;
    end
  end

  // Saturating period and high-time counters; a rising edge restarts at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt_r  <= '0;
      high_cnt_r <= '0;
    end else if (rise_s) begin
      per_cnt_r  <= CNT_W'(1);
      high_cnt_r <= CNT_W'(1);
    end else if (state_r == MEASURE) begin
      per_cnt_r  <= (per_cnt_r == CNT_MAX) ? per_cnt_r : per_cnt_r + CNT_W'(1);
      if (level_s && high_cnt_r != CNT_MAX) begin
        high_cnt_r <= high_cnt_r + CNT_W'(1);
      end
    end
  end

  // Measurement latch, valid strobe and stuck flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      high_time_r  <= '0;
      period_r     <= '0;
      duty_r       <= 8'd0;
      meas_valid_r <= 1'b0;
      stuck_low_r  <= 1'b0;
      stuck_high_r <= 1'b0;
    end else begin
      meas_valid_r <= 1'b0;
      if (state_r == MEASURE && rise_s) begin
        high_time_r  <= high_cnt_r;
        period_r     <= per_cnt_r;
        duty_r       <= duty_sat(32'(high_cnt_r));
        meas_valid_r <= 1'b1;
      end else if (state_r != STUCK && state_s == STUCK) begin
        meas_valid_r <= 1'b1;
        if (level_s) begin
          stuck_high_r <= 1'b1;
          duty_r       <= DUTY_SAT;
        end else begin
          stuck_low_r  <= 1'b1;
          high_time_r  <= '0;
          period_r     <= '0;
          duty_r       <= 8'd0;
        end
      end else if (state_r == STUCK && (rise_s || fall_s)) begin
        stuck_low_r  <= 1'b0;
        stuck_high_r <= 1'b0;
      end
    end
  end

  assign high_time  = high_time_r;
  assign period     = period_r;
  assign duty_cycle = duty_r;
  assign meas_valid = meas_valid_r;
  assign stuck_low  = stuck_low_r;
  assign stuck_high = stuck_high_r;

endmodule
